// File: rtl/tx_xgmii_encoder.sv
// XGMII TX framer: pops frame words from the show-ahead hold FIFO and
// drives 64-bit XGMII columns with /S/ preamble, /T/, /E/ and idle gap.
//
// Ports:
//   clk_xgmii_tx, reset_xgmii_tx    clock, sync active-high reset
//   tx_enable                       0 = finish frame, then stay idle
//   txhfifo_rdata/rstatus           FIFO head word and status
//   txhfifo_rempty/ralmost_empty    FIFO level flags
//   txhfifo_ren                     pop head (combinational)
//   xgmii_txd/xgmii_txc             registered XGMII data/control
//   stat_tx_frame/stat_tx_underrun  one-cycle event pulses

module tx_xgmii_encoder #(
  parameter int IFG_BYTES           = 12,
  parameter int START_THRESH_USE_AE = 1
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx,
  input  logic        tx_enable,
  input  logic [63:0] txhfifo_rdata,
  input  logic [7:0]  txhfifo_rstatus,
  input  logic        txhfifo_rempty,
  input  logic        txhfifo_ralmost_empty,
  output logic        txhfifo_ren,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        stat_tx_frame,
  output logic        stat_tx_underrun
);

  localparam logic [63:0] L_IDLE = {8{8'h07}};
  localparam logic [63:0] L_PRE  = 64'hD5555555555555FB;
  localparam logic [63:0] L_ERR  = {8{8'hFE}};
  localparam logic [63:0] L_TERM = {{7{8'h07}}, 8'hFD};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_TERM,
    S_IFG,
    S_DISCARD
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ifg_cnt;
  logic        r_first;
  logic [63:0] r_txd;
  logic [7:0]  r_txc;
  logic        r_frame;
  logic        r_urun;

  logic        w_avail;
  logic        w_sop;
  logic        w_eop;
  logic        w_err;
  logic [2:0]  w_nvb;
  logic        w_thresh;
  logic        w_start;
  logic        w_ren;
  logic [63:0] w_term_d;
  logic [7:0]  w_term_c;
  logic        w_unused;

  assign w_avail  = !txhfifo_rempty;
  assign w_sop    = txhfifo_rstatus[7];
  assign w_eop    = txhfifo_rstatus[6];
  assign w_err    = txhfifo_rstatus[5];
  assign w_nvb    = txhfifo_rstatus[2:0];
  assign w_unused = ^txhfifo_rstatus[4:3];

  assign w_thresh = (START_THRESH_USE_AE != 0) ?
                    !txhfifo_ralmost_empty : 1'b1;
  assign w_start  = tx_enable & w_avail & w_sop & w_thresh;

  // Idle words still owed after a terminate column with `credit`
  // idle lanes already sent behind the /T/.
  function automatic logic [3:0] f_ifg_words(input logic [2:0] credit);
    int d;
    d = IFG_BYTES - int'(credit);
    if (d < 0) d = 0;
    return 4'((d + 7) / 8);
  endfunction

  // Terminate column built around a short EOP word: data below lane N,
  // FD in lane N, idle above.
  always_comb begin
    w_term_d = L_IDLE;
    w_term_c = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(w_nvb)) begin
        w_term_d[8*i +: 8] = txhfifo_rdata[8*i +: 8];
        w_term_c[i]        = 1'b0;
      end else if (i == int'(w_nvb)) begin
        w_term_d[8*i +: 8] = 8'hFD;
      end
    end
  end

  // The SOP word itself is popped as the first DATA word; any later
  // SOP head is the next frame and is left in the FIFO.
  always_comb begin
    w_ren = 1'b0;
    if (!reset_xgmii_tx && w_avail) begin
      unique case (1'b1)
        (r_state == S_IDLE):
          w_ren = !w_sop;
        (r_state == S_IFG):
          w_ren = (r_ifg_cnt == 4'd0) && !w_sop;
        (r_state == S_DATA):
          w_ren = r_first || !w_sop;
        (r_state == S_DISCARD):
          w_ren = !w_sop;
        default:
          w_ren = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      r_state   <= S_IFG;
      r_ifg_cnt <= 4'd0;
      r_first   <= 1'b0;
      r_txd     <= L_IDLE;
      r_txc     <= 8'hFF;
      r_frame   <= 1'b0;
      r_urun    <= 1'b0;
    end else begin
      r_txd   <= L_IDLE;
      r_txc   <= 8'hFF;
      r_frame <= 1'b0;
      r_urun  <= 1'b0;
      case (r_state)
        S_IDLE, S_IFG: begin
          // IFG with nothing owed behaves exactly like IDLE
          if (r_state == S_IFG && r_ifg_cnt != 4'd0) begin
            r_ifg_cnt <= r_ifg_cnt - 4'd1;
          end else if (w_start) begin
            r_txd   <= L_PRE;
            r_txc   <= 8'h01;
            r_first <= 1'b1;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
            if (w_avail && !w_sop) r_urun <= 1'b1;
          end
        end
        S_DATA: begin
          if (!w_avail) begin
            r_txd   <= L_ERR;
            r_urun  <= 1'b1;
            r_state <= S_DISCARD;
          end else if (w_sop && !r_first) begin
            r_txd     <= L_ERR;
            r_urun    <= 1'b1;
            r_state   <= S_IFG;
            r_ifg_cnt <= f_ifg_words(3'd0);
          end else begin
            r_first <= 1'b0;
            r_txd   <= txhfifo_rdata;
            r_txc   <= 8'h00;
            if (w_eop) begin
              if (w_err) begin
                r_txd   <= L_ERR;
                r_txc   <= 8'hFF;
                r_state <= S_TERM;
              end else if (w_nvb == 3'd0) begin
                r_state <= S_TERM;
              end else begin
                r_txd     <= w_term_d;
                r_txc     <= w_term_c;
                r_frame   <= 1'b1;
                r_state   <= S_IFG;
                r_ifg_cnt <= f_ifg_words(3'd7 - w_nvb);
              end
            end
          end
        end
        S_TERM: begin
          r_txd     <= L_TERM;
          r_frame   <= 1'b1;
          r_state   <= S_IFG;
          r_ifg_cnt <= f_ifg_words(3'd7);
        end
        S_DISCARD: begin
          if (w_avail && (w_sop || w_eop)) begin
            r_state   <= S_IFG;
            r_ifg_cnt <= f_ifg_words(3'd0);
          end
        end
        default: begin
          r_state   <= S_IFG;
          r_ifg_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign txhfifo_ren      = w_ren;
  assign xgmii_txd        = r_txd;
  assign xgmii_txc        = r_txc;
  assign stat_tx_frame    = r_frame;
  assign stat_tx_underrun = r_urun;

endmodule

// File: tb/tb_tx_xgmii_encoder.sv
// Self-checking bench for tx_xgmii_encoder: FIFO model plus a column
// scoreboard, with per-scenario tasks for timing and event counts.

module tb_tx_xgmii_encoder;

  localparam logic [63:0] IDLE_W = {8{8'h07}};
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W  = {8{8'hFE}};
  localparam logic [63:0] TERM_W = {{7{8'h07}}, 8'hFD};

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic [63:0] rdata;
  logic [7:0]  rstatus;
  logic        rempty;
  logic        ralmost_empty;
  logic        ren;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        st_frame;
  logic        st_urun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int urun_cnt = 0;
  int cols_seen = 0;

  logic [71:0] fifo_q[$];
  logic [71:0] exp_q[$];
  int          pre_cyc[$];

  tx_xgmii_encoder #(
    .IFG_BYTES(12),
    .START_THRESH_USE_AE(1)
  ) dut (
    .clk_xgmii_tx(clk),
    .reset_xgmii_tx(rst),
    .tx_enable(tx_enable),
    .txhfifo_rdata(rdata),
    .txhfifo_rstatus(rstatus),
    .txhfifo_rempty(rempty),
    .txhfifo_ralmost_empty(ralmost_empty),
    .txhfifo_ren(ren),
    .xgmii_txd(txd),
    .xgmii_txc(txc),
    .stat_tx_frame(st_frame),
    .stat_tx_underrun(st_urun)
  );

  always #5 clk = ~clk;

  task automatic fifo_refresh();
    rempty        = (fifo_q.size() == 0);
    ralmost_empty = (fifo_q.size() <= 1);
    if (fifo_q.size() > 0) begin
      rdata   = fifo_q[0][63:0];
      rstatus = fifo_q[0][71:64];
    end else begin
      rdata   = 64'h0;
      rstatus = 8'h0;
    end
  endtask

  // FIFO model: pop on ren at the edge, update head 1 time unit later
  always @(posedge clk) begin
    cyc++;
    if (ren === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    fifo_refresh();
  end

  // Scoreboard side: every non-idle column must match the queue head
  always @(negedge clk) begin
    logic [71:0] e;
    if (ren === 1'b1) begin
      total++;
      if (rempty !== 1'b0) begin
        bad++;
        $display("FAIL ren_empty: ren=1 with rempty=%b", rempty);
      end
    end
    if (st_frame === 1'b1) frame_cnt++;
    if (st_urun === 1'b1) urun_cnt++;
    if (!(txd === IDLE_W && txc === 8'hFF)) begin
      if (txd === PRE_W && txc === 8'h01) pre_cyc.push_back(cyc);
      cols_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL col_extra: got %h/%h want none", txd, txc);
      end else begin
        e = exp_q.pop_front();
        if ({txd, txc} !== e) begin
          bad++;
          $display("FAIL col: got %h/%h want %h/%h",
                   txd, txc, e[71:8], e[7:0]);
        end
      end
    end
  end

  // mode 0 = normal EOP, 1 = EOP with ERR, 2 = no EOP (truncated)
  task automatic push_frame(input int nw, input logic [2:0] nl,
                            input int mode);
    logic [63:0] d;
    logic [63:0] pd;
    logic [7:0]  pc;
    logic [7:0]  st;
    bit          last;
    exp_q.push_back({PRE_W, 8'h01});
    for (int i = 0; i < nw; i++) begin
      d    = {$urandom, $urandom};
      st   = 8'h00;
      last = (i == nw - 1);
      if (i == 0) st[7] = 1'b1;
      if (last && mode != 2) begin
        st[6]   = 1'b1;
        st[2:0] = nl;
        if (mode == 1) st[5] = 1'b1;
      end
      fifo_q.push_back({st, d});
      if (last && mode == 1) begin
        exp_q.push_back({ERR_W, 8'hFF});
        exp_q.push_back({TERM_W, 8'hFF});
      end else if (last && mode == 0 && nl != 3'd0) begin
        for (int l = 0; l < 8; l++) begin
          if (l < int'(nl)) begin
            pd[8*l +: 8] = d[8*l +: 8];
            pc[l] = 1'b0;
          end else if (l == int'(nl)) begin
            pd[8*l +: 8] = 8'hFD;
            pc[l] = 1'b1;
          end else begin
            pd[8*l +: 8] = 8'h07;
            pc[l] = 1'b1;
          end
        end
        exp_q.push_back({pd, pc});
      end else begin
        exp_q.push_back({d, 8'h00});
        if (last && mode == 0) exp_q.push_back({TERM_W, 8'hFF});
      end
    end
    if (mode == 2) exp_q.push_back({ERR_W, 8'hFF});
    fifo_refresh();
  endtask

  // Tail of a frame arriving late: no SOP, EOP on the last word
  task automatic push_raw(input int nw);
    logic [7:0] st;
    for (int i = 0; i < nw; i++) begin
      st = (i == nw - 1) ? 8'h40 : 8'h00;
      fifo_q.push_back({st, $urandom, $urandom});
    end
    fifo_refresh();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (txd !== IDLE_W) begin
      bad++;
      $display("FAIL rst_txd: got %h want %h", txd, IDLE_W);
    end
    total++;
    if (txc !== 8'hFF) begin
      bad++;
      $display("FAIL rst_txc: got %h want ff", txc);
    end
    total++;
    if (ren !== 1'b0) begin
      bad++;
      $display("FAIL rst_ren: got %b want 0", ren);
    end
    total++;
    if ({st_frame, st_urun} !== 2'b00) begin
      bad++;
      $display("FAIL rst_stat: got %b want 00", {st_frame, st_urun});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (txd !== IDLE_W || txc !== 8'hFF) begin
      bad++;
      $display("FAIL idle_empty: got %h/%h want idle", txd, txc);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    int k;
    int f0;
    k  = pre_cyc.size();
    f0 = frame_cnt;
    push_frame(8, 3'd0, 0);
    push_frame(2, 3'd0, 0);
    wait_drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_drain: left=%0d want 0", exp_q.size());
    end
    total++;
    if (frame_cnt - f0 != 2) begin
      bad++;
      $display("FAIL full_stat: got %0d want 2", frame_cnt - f0);
    end
    total++;
    if (pre_cyc.size() < k + 2) begin
      bad++;
      $display("FAIL full_pre: got %0d want 2", pre_cyc.size() - k);
    end else if (pre_cyc[k+1] - pre_cyc[k] != 11) begin
      bad++;
      $display("FAIL full_gap: got %0d want 11",
               pre_cyc[k+1] - pre_cyc[k]);
    end
  endtask

  task automatic test_partial_eop();
    bit ok;
    int k;
    k = pre_cyc.size();
    push_frame(2, 3'd4, 0);
    push_frame(2, 3'd0, 0);
    wait_drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL part_drain: left=%0d want 0", exp_q.size());
    end
    total++;
    if (pre_cyc.size() < k + 2) begin
      bad++;
      $display("FAIL part_pre: got %0d want 2", pre_cyc.size() - k);
    end else if (pre_cyc[k+1] - pre_cyc[k] != 5) begin
      bad++;
      $display("FAIL part_gap: got %0d want 5",
               pre_cyc[k+1] - pre_cyc[k]);
    end
  endtask

  task automatic test_err_eop();
    bit ok;
    int f0;
    int u0;
    f0 = frame_cnt;
    u0 = urun_cnt;
    push_frame(2, 3'd0, 1);
    wait_drain(ok);
    @(posedge clk);
    #2;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL err_drain: left=%0d want 0", exp_q.size());
    end
    total++;
    if (frame_cnt - f0 != 1 || urun_cnt != u0) begin
      bad++;
      $display("FAIL err_stat: frame=%0d urun=%0d want 1/0",
               frame_cnt - f0, urun_cnt - u0);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int f0;
    int u0;
    f0 = frame_cnt;
    u0 = urun_cnt;
    push_frame(3, 3'd0, 2);
    wait_drain(ok);
    @(posedge clk);
    #2;
    total++;
    if (!ok || urun_cnt - u0 != 1) begin
      bad++;
      $display("FAIL urun_col: ok=%0d urun=%0d want 1/1",
               ok, urun_cnt - u0);
    end
    push_raw(5);
    push_frame(2, 3'd0, 0);
    wait_drain(ok);
    @(posedge clk);
    #2;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL urun_restart: left=%0d want 0", exp_q.size());
    end
    total++;
    if (urun_cnt - u0 != 1 || frame_cnt - f0 != 1) begin
      bad++;
      $display("FAIL urun_stat: urun=%0d frame=%0d want 1/1",
               urun_cnt - u0, frame_cnt - f0);
    end
    total++;
    if (fifo_q.size() != 0) begin
      bad++;
      $display("FAIL urun_fifo: got %0d want 0", fifo_q.size());
    end
  endtask

  task automatic test_missing_eop();
    bit ok;
    int k;
    int u0;
    k  = pre_cyc.size();
    u0 = urun_cnt;
    push_frame(2, 3'd0, 2);
    push_frame(2, 3'd0, 0);
    wait_drain(ok);
    total++;
    if (!ok || urun_cnt - u0 != 1) begin
      bad++;
      $display("FAIL noeop: ok=%0d urun=%0d want 1/1", ok, urun_cnt - u0);
    end
    total++;
    if (pre_cyc.size() < k + 2) begin
      bad++;
      $display("FAIL noeop_pre: got %0d want 2", pre_cyc.size() - k);
    end else if (pre_cyc[k+1] - pre_cyc[k] != 6) begin
      bad++;
      $display("FAIL noeop_gap: got %0d want 6",
               pre_cyc[k+1] - pre_cyc[k]);
    end
  endtask

  task automatic test_enable();
    bit ok;
    int k;
    int f0;
    int en_cyc;
    repeat (4) @(posedge clk);
    #2;
    k  = pre_cyc.size();
    f0 = frame_cnt;
    push_frame(4, 3'd0, 0);
    push_frame(2, 3'd0, 0);
    for (int i = 0; i < 50; i++) begin
      if (pre_cyc.size() > k) break;
      @(posedge clk);
      #2;
    end
    tx_enable = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    total++;
    if (frame_cnt - f0 != 1) begin
      bad++;
      $display("FAIL en_finish: got %0d want 1", frame_cnt - f0);
    end
    total++;
    if (pre_cyc.size() - k != 1 || exp_q.size() != 4) begin
      bad++;
      $display("FAIL en_hold: pre=%0d left=%0d want 1/4",
               pre_cyc.size() - k, exp_q.size());
    end
    tx_enable = 1'b1;
    en_cyc    = cyc;
    wait_drain(ok);
    total++;
    if (!ok || pre_cyc.size() < k + 2) begin
      bad++;
      $display("FAIL en_resume: ok=%0d pre=%0d want 1/2",
               ok, pre_cyc.size() - k);
    end else if (pre_cyc[k+1] - en_cyc > 1) begin
      bad++;
      $display("FAIL en_lat: got %0d want <=1", pre_cyc[k+1] - en_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int sz;
    int u0;
    int f0;
    repeat (4) @(posedge clk);
    #2;
    base = cols_seen;
    push_frame(6, 3'd0, 0);
    for (int i = 0; i < 50; i++) begin
      if (cols_seen - base >= 3) break;
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    #1;
    total++;
    if (ren !== 1'b0) begin
      bad++;
      $display("FAIL rmid_ren: got %b want 0", ren);
    end
    sz = fifo_q.size();
    @(posedge clk);
    #2;
    total++;
    if (txd !== IDLE_W || txc !== 8'hFF) begin
      bad++;
      $display("FAIL rmid_idle: got %h/%h want idle", txd, txc);
    end
    total++;
    if (fifo_q.size() != sz || sz == 0) begin
      bad++;
      $display("FAIL rmid_fifo: got %0d want %0d", fifo_q.size(), sz);
    end
    rst = 1'b0;
    exp_q.delete();
    u0 = urun_cnt;
    for (int i = 0; i < 50; i++) begin
      if (fifo_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (urun_cnt - u0 != sz) begin
      bad++;
      $display("FAIL rmid_drop: got %0d want %0d", urun_cnt - u0, sz);
    end
    f0 = frame_cnt;
    push_frame(3, 3'd0, 0);
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt - f0 != 1) begin
      bad++;
      $display("FAIL rmid_restart: ok=%0d frame=%0d want 1/1",
               ok, frame_cnt - f0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    tx_enable = 1'b1;
    fifo_refresh();
    test_reset();
    test_full_frame();
    test_partial_eop();
    test_err_eop();
    test_underrun();
    test_missing_eop();
    test_enable();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
